// File: rtl/seq_subtractor58_27_if.sv
// seq_subtractor58_27_if
//   Operand/result handshake bundle for the sequential 58-bit minus 27-bit
//   subtractor.
//   master : the producer/consumer side (drives operands, accepts Diff)
//   slave  : the subtractor side
//   Signals:
//     in_valid / in_ready   operand handshake
//     A (58b), B (27b)      minuend, subtrahend (unsigned)
//     out_valid / out_ready result handshake
//     Diff (59b)            A - B, bit 58 = borrow
//     zero                  Diff == 0 (only when SUB58_ZERO_FLAG_EN is defined)
interface seq_subtractor58_27_if;
  logic        in_valid;
  logic        in_ready;
  logic [57:0] A;
  logic [26:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [58:0] Diff;
`ifdef SUB58_ZERO_FLAG_EN
  logic        zero;
`endif

  modport master (
`ifdef SUB58_ZERO_FLAG_EN
    input  zero,
`endif
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Diff
  );

  modport slave (
`ifdef SUB58_ZERO_FLAG_EN
    output zero,
`endif
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Diff
  );
endinterface

// File: rtl/seq_subtractor58_27.sv
// seq_subtractor58_27
//   Sequential subtractor: Diff = A - zero_extend(B) as a 59-bit two's
//   complement value (bit 58 = borrow). Operands are latched in IDLE, then
//   four CALC cycles each subtract one 16-bit slice (the last one 10 bits)
//   while rippling the borrow, then the result is offered in DONE until
//   out_ready is seen.
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : seq_subtractor58_27_if.slave (in/out handshakes, A, B, Diff)
//   Optional feature macro: SUB58_ZERO_FLAG_EN adds bus.zero (Diff == 0),
//   registered together with the final slice, cleared on handshake/reset.
module seq_subtractor58_27 #(
  parameter int SLICE_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  seq_subtractor58_27_if.slave   bus
);

  localparam int NUM_SLICES = 4;
  localparam int PAD_W      = SLICE_W * NUM_SLICES;
  localparam int LAST_LO    = SLICE_W * (NUM_SLICES - 1);
  localparam int LAST_W     = 58 - LAST_LO;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_reg, state_next;
  logic [57:0] a_reg;
  logic [57:0] b_reg;
  logic        borrow_reg;
  logic [1:0]  idx_reg;
  logic [58:0] diff_reg;
  logic [58:0] diff_next;
  logic        in_ready;
  logic        out_valid;

  // Operands padded to a whole number of slices; the pad bits are zero, so
  // the borrow out of the padded top slice equals the borrow of its 10-bit
  // payload.
  logic [PAD_W-1:0]   a_pad, b_pad;
  logic [SLICE_W-1:0] a_slice [NUM_SLICES];
  logic [SLICE_W-1:0] b_slice [NUM_SLICES];
  logic [SLICE_W-1:0] a_cur, b_cur;
  logic [SLICE_W:0]   slice_res;

  assign a_pad = {{(PAD_W-58){1'b0}}, a_reg};
  assign b_pad = {{(PAD_W-58){1'b0}}, b_reg};

  generate
    for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
      assign a_slice[gi] = a_pad[gi*SLICE_W +: SLICE_W];
      assign b_slice[gi] = b_pad[gi*SLICE_W +: SLICE_W];
    end
  endgenerate

  assign a_cur = a_slice[idx_reg];
  assign b_cur = b_slice[idx_reg];

  // One extra bit on the left catches the borrow-out of this slice.
  assign slice_res = {1'b0, a_cur} - {1'b0, b_cur} - {{SLICE_W{1'b0}}, borrow_reg};

  // Merge the current slice result into the running difference.
  always_comb begin
    diff_next = diff_reg;
    for (int i = 0; i < NUM_SLICES - 1; i++) begin
      if (idx_reg == 2'(i)) begin
        diff_next[i*SLICE_W +: SLICE_W] = slice_res[SLICE_W-1:0];
      end
    end
    if (idx_reg == 2'(NUM_SLICES - 1)) begin
      diff_next[LAST_LO +: LAST_W] = slice_res[LAST_W-1:0];
      diff_next[58]                = slice_res[SLICE_W];
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_next = CALC;
      end
      CALC: begin
        if (idx_reg == 2'(NUM_SLICES - 1)) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      borrow_reg <= 1'b0;
      idx_reg    <= '0;
      diff_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg      <= bus.A;
            b_reg      <= {31'b0, bus.B};
            borrow_reg <= 1'b0;
            idx_reg    <= '0;
          end
        end
        CALC: begin
          diff_reg   <= diff_next;
          borrow_reg <= slice_res[SLICE_W];
          idx_reg    <= idx_reg + 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef SUB58_ZERO_FLAG_EN
  logic zero_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_reg <= 1'b0;
    end else if (state_reg == CALC && idx_reg == 2'(NUM_SLICES - 1)) begin
      zero_reg <= (diff_next == '0);
    end else if (state_reg == DONE && bus.out_ready) begin
      zero_reg <= 1'b0;
    end
  end

  assign bus.zero = zero_reg;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.Diff      = diff_reg;

endmodule

// File: doc/seq_subtractor58_27.md
SEQ_SUBTRACTOR58_27 -- requirements
Module: seq_subtractor58_27

Interface
REQ-001 Parameter: SLICE_W, 16, width in bits of the slice processed per CALC cycle; fixed at 16 for this release.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operands A/B valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 A  input  58  minuend, unsigned.
REQ-007 B  input  27  subtrahend, unsigned, zero-extended to 58 bits internally.
REQ-008 out_valid  output  1  Diff valid.
REQ-009 out_ready  input  1  consumer accepts Diff.
REQ-010 Diff  output  59  A - {31'b0,B} as 59-bit two's complement; bit 58 = borrow (1 iff A < B).
REQ-011 Reset is asynchronous and active-high on rst; the block has one clock, clk.

Function
REQ-012 FSM states: IDLE, CALC, DONE; IDLE is the reset state.
REQ-013 IDLE: in_ready=1; on in_valid=1, latch A and zero-extended B, clear borrow, clear slice index, go CALC.
REQ-014 CALC: in_ready=0; each edge subtracts one 16-bit slice (slices [15:0], [31:16], [47:32], [57:48]) with borrow-in from the previous slice and stores the result slice and borrow-out.
REQ-015 CALC lasts exactly 4 edges; the 4th edge writes the final 10-bit slice, sets Diff[58] = final borrow, and goes DONE.
REQ-016 Latency: out_valid rises exactly 5 rising edges after the accepting edge (1 accept + 4 CALC).
REQ-017 DONE: out_valid=1, Diff stable; on out_ready=1, go IDLE; out_valid deasserts on that same edge.
REQ-018 out_ready=0 in DONE holds Diff and out_valid indefinitely.
REQ-019 Throughput: one operation per 6 cycles minimum; no acceptance while CALC or DONE (in_ready=0), and in_valid in those states is ignored.
REQ-020 A and B changes after the accepting edge do not affect the result.
REQ-021 Diff holds its last result in IDLE; it is only written in CALC.
REQ-022 Diff is exact across the full range, with no saturation; A=0,B>0 produces the wrapped 59-bit two's complement.

Reset
REQ-023 rst=1 forces IDLE, in_ready=1 after release, out_valid=0, Diff=0, borrow=0, slice index=0 immediately without waiting for a clock.
REQ-024 rst asserted in CALC or DONE aborts the operation; no out_valid is produced for it.

Configuration
REQ-025 Macro SUB58_ZERO_FLAG_EN: when defined, adds output port zero (1 bit), valid with out_valid, =1 iff Diff==0, reset 0; when undefined, the port and its logic are absent and all other behaviour is unchanged.

Verification
REQ-026 A=100, B=1, out_ready=1 -> out_valid 5 edges after accept, Diff=99, Diff[58]=0.
REQ-027 A=0, B=1 -> Diff=0x7FF_FFFF_FFFF_FFFF (borrow=1).
REQ-028 A=0x3FF_FFFF_FFFF_FFFF, B=0x7FF_FFFF -> Diff=0x3FF_FFFF_F800_0000, borrow=0 (checks the cross-slice borrow chain).
REQ-029 out_ready=0 for 10 cycles in DONE, with in_valid=1 and new operands -> Diff/out_valid held, in_ready=0, second operand not accepted until the cycle after out_ready=1 handshake.
REQ-030 rst pulsed mid-CALC (2nd CALC edge) -> immediate IDLE, out_valid=0, Diff=0; next operation A=7,B=3 -> Diff=4.
REQ-031 With SUB58_ZERO_FLAG_EN: A=5, B=5 -> Diff=0, zero=1; A=6, B=5 -> zero=0.
